// File: rtl/serial_frame_rx_if.sv
// rtl/serial_frame_rx_if.sv - serial line and parallel output bundle for serial_frame_rx
//
// Signals:
//   serial_in   serial line (idles high), into the receiver
//   data_out    received word, stable while data_valid is high
//   data_valid  data_out holds an unconsumed word
//   data_ready  consumer accepts the word on data_valid && data_ready
//   busy        receiver is inside a frame
//   frame_err   one-cycle pulse, stop bit sampled low
//   overrun     one-cycle pulse, good frame dropped (holding register full)
// Modports: master = receiver side, slave = line driver / consumer side.
interface serial_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic              serial_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              busy;
    logic              frame_err;
    logic              overrun;

    modport master (
        input  serial_in,
        input  data_ready,
        output data_out,
        output data_valid,
        output busy,
        output frame_err,
        output overrun
    );

    modport slave (
        output serial_in,
        output data_ready,
        input  data_out,
        input  data_valid,
        input  busy,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - start/data/stop serial frame receiver with holding register
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    serial_frame_rx_if.master (serial_in, data_ready in; data_out,
//          data_valid, busy, frame_err, overrun out)
// Parameters:
//   DATA_W      data bits per frame, LSB first
//   BIT_CYCLES  clk cycles per serial bit; sampling happens BIT_CYCLES/2
//               cycles after the start edge and every BIT_CYCLES after that
module serial_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input logic               clk,
    input logic               reset,
    serial_frame_rx_if.master bus
);
    localparam int HALF  = BIT_CYCLES / 2;
    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam int IDX_W = $clog2(DATA_W + 1);

    // Counter values seen just before the sampling edge.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              busy_q;
    logic              ferr_q;
    logic              ovr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;

            // Consumer handshake; a load at the stop edge below overrides it.
            if (valid_q && bus.data_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!bus.serial_in) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (bus.serial_in) begin
                            // Line went back high by mid start bit: glitch.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        // LSB first: new bit enters at the top and walks down.
                        shreg_q <= (shreg_q >> 1) | (DATA_W'(bus.serial_in) << (DATA_W - 1));
                        if (idx_q == IDX_LAST) begin
                            state_q <= STOP;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (!bus.serial_in) begin
                            ferr_q <= 1'b1;
                        end else if (!valid_q || bus.data_ready) begin
                            data_q  <= shreg_q;
                            valid_q <= 1'b1;
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - directed and randomized bench for serial_frame_rx
module tb_serial_frame_rx;
    localparam int DW    = 8;
    localparam int BC    = 4;
    localparam int HALF  = BC / 2;
    localparam int TS    = HALF + (DW + 1) * BC;   // stop sample edge, relative to start detection
    localparam int FRAME = (DW + 2) * BC;           // edges a full frame occupies on the line

    logic clk = 1'b0;
    logic reset;

    serial_frame_rx_if #(.DATA_W(DW)) bus ();

    serial_frame_rx #(.DATA_W(DW), .BIT_CYCLES(BC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a one-entry holding register plus expected pulses.
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic          exp_ferr;
    logic          exp_ovr;
    logic          exp_busy;
    int            ready_mode;   // 0: leave data_ready, 1: random per cycle, 2: pulse at stop edge

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("data_valid", 32'(bus.data_valid), 32'(exp_valid));
        chk("data_out",   32'(bus.data_out),   32'(exp_data));
        chk("frame_err",  32'(bus.frame_err),  32'(exp_ferr));
        chk("overrun",    32'(bus.overrun),    32'(exp_ovr));
        chk("busy",       32'(bus.busy),       32'(exp_busy));
    endtask

    task automatic model_clear();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        exp_busy  = 1'b0;
    endtask

    // ev: 0 plain cycle, 1 good frame completes at this edge, 2 bad stop bit at this edge.
    task automatic tick(input int ev, input logic [DW-1:0] w);
        if (ready_mode == 1) bus.data_ready = 1'($urandom_range(0, 1));
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        if (ev == 1) begin
            if (!exp_valid || bus.data_ready) begin
                exp_data  = w;
                exp_valid = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end else begin
            if (ev == 2) exp_ferr = 1'b1;
            if (exp_valid && bus.data_ready) exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        bus.serial_in = 1'b1;
        exp_busy = 1'b0;
        for (int i = 0; i < n; i++) tick(0, '0);
    endtask

    // Drives one frame; k counts edges from start detection. Stops early after nedges.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit, input int nedges);
        logic [DW+1:0] bits;
        int k;
        int ev;
        bits = {stop_bit, d, 1'b0};
        for (int b = 0; b < DW + 2; b++) begin
            for (int c = 0; c < BC; c++) begin
                k = b * BC + c;
                if (k >= nedges) return;
                // After the stop sample the line returns high so no new start is seen.
                bus.serial_in = (k > TS) ? 1'b1 : bits[b];
                exp_busy = (k < TS);
                ev = (k == TS) ? (stop_bit ? 1 : 2) : 0;
                if (ready_mode == 2) bus.data_ready = (k == TS);
                tick(ev, d);
            end
        end
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          rs;

        reset = 1'b1;
        bus.serial_in  = 1'b1;
        bus.data_ready = 1'b0;
        ready_mode = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #2 reset = 1'b0;
        idle(3);

        // Single frame, consumer always ready.
        bus.data_ready = 1'b1;
        send_frame(8'hA5, 1'b1, FRAME);
        idle(2);

        // One-cycle low glitch on the line.
        bus.serial_in = 1'b0;
        exp_busy = 1'b1;
        tick(0, '0);
        bus.serial_in = 1'b1;
        tick(0, '0);
        exp_busy = 1'b0;
        tick(0, '0);
        idle(3);

        // Bad stop bit, then a good frame.
        send_frame(8'h3C, 1'b0, FRAME);
        idle(2);
        send_frame(8'h11, 1'b1, FRAME);
        idle(2);

        // Consumer stalled: second frame overruns.
        bus.data_ready = 1'b0;
        send_frame(8'h12, 1'b1, FRAME);
        send_frame(8'h34, 1'b1, FRAME);
        idle(2);
        bus.data_ready = 1'b1;
        idle(2);

        // Consume and load on the same edge.
        bus.data_ready = 1'b0;
        send_frame(8'h12, 1'b1, FRAME);
        ready_mode = 2;
        send_frame(8'h34, 1'b1, FRAME);
        ready_mode = 0;
        idle(3);

        // Reset mid-frame with a word still held.
        send_frame(8'h5A, 1'b1, FRAME);
        send_frame(8'hC3, 1'b1, 5 * BC + 2);
        #2 reset = 1'b1;
        #1;
        model_clear();
        check_all();
        bus.serial_in = 1'b1;
        tick(0, '0);
        #2 reset = 1'b0;
        idle(2);
        bus.data_ready = 1'b1;
        send_frame(8'hFF, 1'b1, FRAME);
        idle(2);

        // Randomized frames, stop bits, gaps and consumer readiness.
        ready_mode = 1;
        for (int i = 0; i < 24; i++) begin
            rd = DW'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            send_frame(rd, rs, FRAME);
            idle(int'($urandom_range(0, 3)));
        end
        ready_mode = 0;
        bus.data_ready = 1'b1;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Receives asynchronous-style serial frames (1 start bit low, DATA_W data bits LSB first, 1 stop bit high) from a single-bit line and produces a parallel word.
Sits downstream of the serial shift stages and upstream of parallel consumers.
Provides mid-bit sampling, frame checking and a valid/ready output holding register with overrun detection.

Parameters:
DATA_W, 8, data bits per frame (>=1)
BIT_CYCLES, 4, clk cycles per serial bit (>=2); HALF = BIT_CYCLES/2 (integer floor)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
serial_in  input  1  serial line, idles high, synchronous to clk (no internal synchronizer)
data_out  output  DATA_W  received word, stable while data_valid=1
data_valid  output  1  data_out holds an unconsumed word
data_ready  input  1  consumer accepts word when data_valid&&data_ready at a clk edge
busy  output  1  high in any state other than IDLE
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: good frame dropped because holding register was full

Behaviour:
- Reset (async, any time including mid-frame): FSM->IDLE, all counters 0, shift register 0, data_out=0, data_valid=0, busy=0, frame_err=0, overrun=0.
- FSM states IDLE, START, DATA, STOP; one cycle counter and one bit index.
- IDLE: edge t0 where serial_in=0 -> START, counter cleared. serial_in=1 -> stay.
- START: at edge t0+HALF, resample serial_in. 0 -> DATA, counter cleared. 1 -> IDLE (glitch rejected, no flags).
- DATA: bit i (i=0..DATA_W-1) sampled at edge t0+HALF+(i+1)*BIT_CYCLES. Shifted in LSB first: shreg <= {serial_in, shreg[DATA_W-1:1]}. After bit DATA_W-1 -> STOP.
- STOP: sampled at edge ts = t0+HALF+(DATA_W+1)*BIT_CYCLES, then -> IDLE.
  - Sample 1: frame good.
  - Sample 0: frame_err=1 for the cycle after ts, data discarded, data_valid unchanged.
- IDLE is re-entered at ts, so the next start bit is detectable from edge ts+1.
- Good frame at ts:
  - Holding register empty (data_valid=0), or being consumed at ts (data_valid&&data_ready): data_out<=shreg, data_valid=1 from cycle after ts, no overrun.
  - Holding register full and not consumed at ts: data_out and data_valid unchanged, overrun=1 for the cycle after ts, new word dropped.
- Consume: at any edge with data_valid&&data_ready and no simultaneous load, data_valid<=0; data_out holds its last value.
- data_valid never drops without a handshake (except reset). data_ready is ignored while data_valid=0.
- busy = (state!=IDLE), registered with state.
- serial_in is not examined in DATA/STOP except at the sample edges.
- Total latency from start-bit detection to data_valid: HALF+(DATA_W+1)*BIT_CYCLES+1 cycles.

Test Plan:
- DATA_W=8, BIT_CYCLES=4, data_ready=1: send frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop=1), each bit held 4 cycles -> data_valid=1 for exactly 1 cycle, data_out=0xA5, 39 cycles after start detection, frame_err=0, overrun=0.
- serial_in low for 1 cycle only, then high -> busy high 2 cycles, returns to IDLE, no data_valid, no flags.
- Frame 0x3C with stop bit driven 0 -> frame_err pulses 1 cycle, data_valid stays 0, next frame 0x11 received correctly.
- data_ready=0, send 0x12 then 0x34 back-to-back -> data_out=0x12 held with data_valid=1, overrun pulses once at second frame end. Raise data_ready -> data_valid drops next cycle, data_out still 0x12.
- data_ready asserted exactly at the edge the second frame completes (valid=1 with 0x12) -> data_out=0x34, data_valid stays 1, overrun=0.
- Assert reset during data bit 4 of a frame -> all outputs 0 asynchronously. After release, a fresh 0xFF frame is received correctly with no stale bits.
